// File: rtl/hdc_am_classifier_pkg.sv
// Shared constants and types for the hypervector associative-memory classifier.
// Widths here are the defaults; the classifier re-derives them from its own parameters.
package hdc_pkg;

   localparam int DIMENSIONS = 10000;
   localparam int CHUNK      = 100;
   localparam int NUM_CHUNKS = DIMENSIONS / CHUNK;
   localparam int DIST_W     = $clog2(DIMENSIONS + 1);

   typedef enum logic {IDLE, RUN} am_state_t;

   typedef logic [DIST_W-1:0] dist_t;

endpackage

// File: rtl/hdc_am_classifier_if.sv
// Query/prototype inputs and classification results between the bundler side and the classifier.
// The master drives the query and prototypes; the slave is the classifier.
interface hdc_am_if #(
   parameter int DIMENSIONS = hdc_pkg::DIMENSIONS,
   parameter int DIST_W     = $clog2(DIMENSIONS + 1)
);

   logic                  start;
   logic [DIMENSIONS-1:0] hv_in;
   logic [DIMENSIONS-1:0] class0_hv;
   logic [DIMENSIONS-1:0] class1_hv;
   logic                  busy;
   logic                  done;
   logic                  label;
   logic [DIST_W-1:0]     dist0;
   logic [DIST_W-1:0]     dist1;

   modport master (
      output start, hv_in, class0_hv, class1_hv,
      input  busy, done, label, dist0, dist1
   );

   modport slave (
      input  start, hv_in, class0_hv, class1_hv,
      output busy, done, label, dist0, dist1
   );

endinterface

// File: rtl/hdc_am_classifier_popcount.sv
// Purely combinational population count of a WIDTH-bit vector.
module hdc_popcount #(
   parameter int WIDTH = 100
) (
   input  logic [WIDTH-1:0]             bits,
   output logic [$clog2(WIDTH+1)-1:0]   count
);

   localparam int CW = $clog2(WIDTH + 1);

   always_comb begin
      count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count = count + CW'(bits[i]);
      end
   end

endmodule

// File: rtl/hdc_am_classifier.sv
// Chunk-serial Hamming-distance classifier: compares a latched query against the
// interictal and ictal prototypes CHUNK bits per cycle and reports the closer class.
module hdc_am_classifier #(
   parameter int DIMENSIONS = hdc_pkg::DIMENSIONS,
   parameter int CHUNK      = hdc_pkg::CHUNK
) (
   input logic     clk,
   input logic     nrst,
   hdc_am_if.slave am
);

   import hdc_pkg::*;

   localparam int numChunks = DIMENSIONS / CHUNK;
   localparam int distW     = $clog2(DIMENSIONS + 1);
   localparam int pcW       = $clog2(CHUNK + 1);
   localparam int idxW      = (numChunks > 1) ? $clog2(numChunks) : 1;
   localparam logic [idxW-1:0] lastIdx = idxW'(numChunks - 1);

   generate
      if (DIMENSIONS % CHUNK != 0) begin : g_bad_chunk
         $error("hdc_am_classifier: DIMENSIONS must be a multiple of CHUNK");
      end
   endgenerate

   am_state_t             state_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  label_q;
   logic [distW-1:0]      dist0_q;
   logic [distW-1:0]      dist1_q;
   logic [distW-1:0]      acc0_q;
   logic [distW-1:0]      acc1_q;
   logic [idxW-1:0]       idx_q;
   logic [DIMENSIONS-1:0] query_q;

   logic [distW-1:0]      sum0_d;
   logic [distW-1:0]      sum1_d;
   logic [CHUNK-1:0]      diff0;
   logic [CHUNK-1:0]      diff1;
   logic [pcW-1:0]        pc0;
   logic [pcW-1:0]        pc1;
   int                    chunkBase;

   assign chunkBase = int'(idx_q) * CHUNK;
   assign diff0     = query_q[chunkBase +: CHUNK] ^ am.class0_hv[chunkBase +: CHUNK];
   assign diff1     = query_q[chunkBase +: CHUNK] ^ am.class1_hv[chunkBase +: CHUNK];

   hdc_popcount #(.WIDTH(CHUNK)) u_pc0 (
      .bits  (diff0),
      .count (pc0)
   );

   hdc_popcount #(.WIDTH(CHUNK)) u_pc1 (
      .bits  (diff1),
      .count (pc1)
   );

   // Running sums including the current chunk; on the last chunk these are the final distances.
   assign sum0_d = acc0_q + distW'(pc0);
   assign sum1_d = acc1_q + distW'(pc1);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         label_q <= 1'b0;
         dist0_q <= '0;
         dist1_q <= '0;
         acc0_q  <= '0;
         acc1_q  <= '0;
         idx_q   <= '0;
         query_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (am.start) begin
                  query_q <= am.hv_in;
                  acc0_q  <= '0;
                  acc1_q  <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (idx_q == lastIdx) begin
                  // Ties favour interictal: seizure only on a strictly closer ictal match.
                  dist0_q <= sum0_d;
                  dist1_q <= sum1_d;
                  label_q <= (sum1_d < sum0_d);
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  idx_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  acc0_q <= sum0_d;
                  acc1_q <= sum1_d;
                  idx_q  <= idx_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign am.busy  = busy_q;
   assign am.done  = done_q;
   assign am.label = label_q;
   assign am.dist0 = dist0_q;
   assign am.dist1 = dist1_q;

endmodule

// File: tb/tb_hdc_am_classifier.sv
// Bench for hdc_am_classifier: a 10000/100 instance for full-size random runs and a
// 16/4 instance for hand-checked corner cases, both compared against plain Hamming math.
module tb_hdc_am_classifier;

   localparam int BD = 10000;
   localparam int BC = 100;
   localparam int BN = BD / BC;
   localparam int BW = $clog2(BD + 1);
   localparam int SD = 16;
   localparam int SC = 4;
   localparam int SN = SD / SC;
   localparam int SW = $clog2(SD + 1);

   logic clk = 1'b0;
   logic nrst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hdc_am_if #(.DIMENSIONS(BD)) ifBig ();
   hdc_am_if #(.DIMENSIONS(SD)) ifSmall ();

   hdc_am_classifier #(.DIMENSIONS(BD), .CHUNK(BC)) dutBig (
      .clk  (clk),
      .nrst (nrst),
      .am   (ifBig)
   );

   hdc_am_classifier #(.DIMENSIONS(SD), .CHUNK(SC)) dutSmall (
      .clk  (clk),
      .nrst (nrst),
      .am   (ifSmall)
   );

   function automatic logic [BD-1:0] randomHv();
      logic [BD-1:0] v;
      for (int i = 0; i < BD; i += 16) v[i +: 16] = 16'($urandom);
      return v;
   endfunction

   // Start a small-instance run, optionally re-pulse start at observation cycle pulseAt,
   // and record when done appears and how long busy stays high.
   task automatic smallRun(input logic [SD-1:0] hv, input logic [SD-1:0] hvAfter, input int pulseAt,
                           output int doneAt, output int busyCnt, output int doneCnt);
      @(negedge clk);
      ifSmall.hv_in = hv;
      ifSmall.start = 1'b1;
      @(posedge clk);
      doneAt = -1;
      busyCnt = 0;
      doneCnt = 0;
      for (int j = 0; j < SN + 4; j++) begin
         @(negedge clk);
         ifSmall.start = (j == pulseAt);
         ifSmall.hv_in = hvAfter;
         if (ifSmall.busy === 1'b1) busyCnt++;
         if (ifSmall.done === 1'b1) begin
            doneCnt++;
            if (doneAt < 0) doneAt = j;
         end
      end
      ifSmall.start = 1'b0;
   endtask

   task automatic bigRun(input logic [BD-1:0] hv, output int doneAt);
      @(negedge clk);
      ifBig.hv_in = hv;
      ifBig.start = 1'b1;
      @(posedge clk);
      doneAt = -1;
      for (int j = 0; j < BN + 5 && doneAt < 0; j++) begin
         @(negedge clk);
         ifBig.start = 1'b0;
         ifBig.hv_in = ~hv;
         if (ifBig.done === 1'b1) doneAt = j;
      end
      ifBig.start = 1'b0;
   endtask

   task automatic test_reset();
      logic [BD-1:0] c0, c1;
      int doneAt, busyCnt, doneCnt, expD1;
      checks++;
      if ({ifBig.busy, ifBig.done, ifBig.label, ifBig.dist0, ifBig.dist1} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_init_big got busy=%b done=%b label=%b d0=%0d d1=%0d required all 0",
                  ifBig.busy, ifBig.done, ifBig.label, ifBig.dist0, ifBig.dist1);
      end
      checks++;
      if ({ifSmall.busy, ifSmall.done, ifSmall.label, ifSmall.dist0, ifSmall.dist1} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_init_small got busy=%b done=%b label=%b d0=%0d d1=%0d required all 0",
                  ifSmall.busy, ifSmall.done, ifSmall.label, ifSmall.dist0, ifSmall.dist1);
      end
      @(negedge clk);
      nrst = 1'b1;
      ifSmall.class0_hv = 16'h0000;
      ifSmall.class1_hv = 16'hFFFF;
      smallRun(16'h0FFF, 16'h0FFF, -1, doneAt, busyCnt, doneCnt);
      @(negedge clk);
      nrst = 1'b0;
      #1;
      checks++;
      if ({ifSmall.busy, ifSmall.done, ifSmall.label, ifSmall.dist0, ifSmall.dist1} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid_sim got busy=%b done=%b label=%b d0=%0d d1=%0d required all 0",
                  ifSmall.busy, ifSmall.done, ifSmall.label, ifSmall.dist0, ifSmall.dist1);
      end
      @(negedge clk);
      nrst = 1'b1;
      c0 = randomHv();
      c1 = randomHv();
      ifBig.class0_hv = c0;
      ifBig.class1_hv = c1;
      expD1 = $countones(c0 ^ c1);
      repeat (BN) @(posedge clk);
      bigRun(c0, doneAt);
      checks++;
      if (doneAt != BN) begin
         errors++;
         $display("[TB] FAIL reset_big_latency got %0d required %0d", doneAt, BN);
      end
      checks++;
      if (ifBig.dist0 !== BW'(0) || ifBig.dist1 !== BW'(expD1) || ifBig.label !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_big_result got d0=%0d d1=%0d label=%b required d0=0 d1=%0d label=0",
                  ifBig.dist0, ifBig.dist1, ifBig.label, expD1);
      end
   endtask

   task automatic test_tie();
      int doneAt, busyCnt, doneCnt;
      ifSmall.class0_hv = 16'h0000;
      ifSmall.class1_hv = 16'hFFFF;
      smallRun(16'h00FF, 16'h00FF, -1, doneAt, busyCnt, doneCnt);
      checks++;
      if (doneAt != SN) begin
         errors++;
         $display("[TB] FAIL tie_latency got %0d required %0d", doneAt, SN);
      end
      checks++;
      if (ifSmall.dist0 !== SW'(8) || ifSmall.dist1 !== SW'(8) || ifSmall.label !== 1'b0) begin
         errors++;
         $display("[TB] FAIL tie_result got d0=%0d d1=%0d label=%b required d0=8 d1=8 label=0",
                  ifSmall.dist0, ifSmall.dist1, ifSmall.label);
      end
   endtask

   task automatic test_latched_query();
      int doneAt, busyCnt, doneCnt;
      smallRun(16'h0FFF, 16'h0000, -1, doneAt, busyCnt, doneCnt);
      checks++;
      if (ifSmall.dist0 !== SW'(12) || ifSmall.dist1 !== SW'(4) || ifSmall.label !== 1'b1) begin
         errors++;
         $display("[TB] FAIL latched_result got d0=%0d d1=%0d label=%b required d0=12 d1=4 label=1",
                  ifSmall.dist0, ifSmall.dist1, ifSmall.label);
      end
   endtask

   task automatic test_start_during_run();
      int doneAt, busyCnt, doneCnt;
      logic [SD-1:0] hv;
      hv = 16'h00F3;
      smallRun(hv, 16'hAAAA, 1, doneAt, busyCnt, doneCnt);
      checks++;
      if (doneCnt != 1 || busyCnt != SN || doneAt != SN) begin
         errors++;
         $display("[TB] FAIL restart_ignored got dones=%0d busy=%0d doneAt=%0d required 1 %0d %0d",
                  doneCnt, busyCnt, doneAt, SN, SN);
      end
      checks++;
      if (ifSmall.dist0 !== SW'($countones(hv ^ ifSmall.class0_hv)) ||
          ifSmall.dist1 !== SW'($countones(hv ^ ifSmall.class1_hv))) begin
         errors++;
         $display("[TB] FAIL restart_result got d0=%0d d1=%0d required d0=6 d1=10",
                  ifSmall.dist0, ifSmall.dist1);
      end
   endtask

   task automatic test_start_in_done_cycle();
      int j, doneAt;
      bit seen, heldBad;
      @(negedge clk);
      ifSmall.hv_in = 16'h0FFF;
      ifSmall.start = 1'b1;
      @(posedge clk);
      seen = 1'b0;
      for (j = 0; j < SN + 4 && !seen; j++) begin
         @(negedge clk);
         ifSmall.start = 1'b0;
         if (ifSmall.done === 1'b1) begin
            seen = 1'b1;
            ifSmall.hv_in = 16'h0001;
            ifSmall.start = 1'b1;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL done_cycle_first got no done required done within %0d cycles", SN + 4);
      end
      @(posedge clk);
      doneAt = -1;
      heldBad = 1'b0;
      for (j = 0; j < SN + 4 && doneAt < 0; j++) begin
         @(negedge clk);
         ifSmall.start = 1'b0;
         if (ifSmall.done === 1'b1) doneAt = j;
         else if (ifSmall.dist0 !== SW'(12) || ifSmall.dist1 !== SW'(4) || ifSmall.label !== 1'b1)
            heldBad = 1'b1;
      end
      checks++;
      if (heldBad) begin
         errors++;
         $display("[TB] FAIL done_cycle_held got results changed before second done required d0=12 d1=4 label=1 held");
      end
      checks++;
      if (doneAt != SN) begin
         errors++;
         $display("[TB] FAIL done_cycle_accept got doneAt=%0d required %0d", doneAt, SN);
      end
      checks++;
      if (ifSmall.dist0 !== SW'(1) || ifSmall.dist1 !== SW'(15) || ifSmall.label !== 1'b0) begin
         errors++;
         $display("[TB] FAIL done_cycle_result got d0=%0d d1=%0d label=%b required d0=1 d1=15 label=0",
                  ifSmall.dist0, ifSmall.dist1, ifSmall.label);
      end
   endtask

   task automatic test_reset_mid_run();
      int doneAt, busyCnt, doneCnt, strayDone;
      @(negedge clk);
      ifSmall.hv_in = 16'hFFFF;
      ifSmall.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifSmall.start = 1'b0;
      @(negedge clk);
      nrst = 1'b0;
      #1;
      checks++;
      if ({ifSmall.busy, ifSmall.done, ifSmall.label, ifSmall.dist0, ifSmall.dist1} !== '0) begin
         errors++;
         $display("[TB] FAIL abort_outputs got busy=%b done=%b label=%b d0=%0d d1=%0d required all 0",
                  ifSmall.busy, ifSmall.done, ifSmall.label, ifSmall.dist0, ifSmall.dist1);
      end
      @(negedge clk);
      nrst = 1'b1;
      strayDone = 0;
      for (int j = 0; j < SN + 4; j++) begin
         @(negedge clk);
         if (ifSmall.done !== 1'b0 || ifSmall.busy !== 1'b0) strayDone++;
      end
      checks++;
      if (strayDone != 0) begin
         errors++;
         $display("[TB] FAIL abort_no_done got %0d active cycles required 0", strayDone);
      end
      smallRun(16'h000F, 16'hFFFF, -1, doneAt, busyCnt, doneCnt);
      checks++;
      if (doneAt != SN || ifSmall.dist0 !== SW'(4) || ifSmall.dist1 !== SW'(12) || ifSmall.label !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_fresh_run got doneAt=%0d d0=%0d d1=%0d label=%b required %0d 4 12 0",
                  doneAt, ifSmall.dist0, ifSmall.dist1, ifSmall.label, SN);
      end
   endtask

   task automatic test_random();
      logic [BD-1:0] c0, c1, hv, mask;
      int doneAt, e0, e1;
      logic eLabel;
      for (int run = 0; run < 50; run++) begin
         c0 = randomHv();
         c1 = randomHv();
         mask = randomHv() & randomHv() & randomHv();
         case (run % 3)
            0: hv = randomHv();
            1: hv = c0 ^ mask;
            default: hv = c1 ^ mask;
         endcase
         @(negedge clk);
         ifBig.class0_hv = c0;
         ifBig.class1_hv = c1;
         e0 = $countones(hv ^ c0);
         e1 = $countones(hv ^ c1);
         eLabel = (e1 < e0);
         bigRun(hv, doneAt);
         checks++;
         if (doneAt != BN) begin
            errors++;
            $display("[TB] FAIL random_latency run %0d got %0d required %0d", run, doneAt, BN);
         end
         checks++;
         if (ifBig.dist0 !== BW'(e0) || ifBig.dist1 !== BW'(e1) || ifBig.label !== eLabel) begin
            errors++;
            $display("[TB] FAIL random_result run %0d got d0=%0d d1=%0d label=%b required d0=%0d d1=%0d label=%b",
                     run, ifBig.dist0, ifBig.dist1, ifBig.label, e0, e1, eLabel);
         end
      end
   endtask

   initial begin
      ifBig.start = 1'b0;
      ifBig.hv_in = '0;
      ifBig.class0_hv = '0;
      ifBig.class1_hv = '0;
      ifSmall.start = 1'b0;
      ifSmall.hv_in = '0;
      ifSmall.class0_hv = '0;
      ifSmall.class1_hv = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_tie();
      test_latched_query();
      test_start_during_run();
      test_start_in_done_cycle();
      test_reset_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
